riscv_mtimer: RTL

- Machine-level timer producing the mtime/mtimecmp pair defined by the privileged spec 1.10 state package.
- Drives the MTIP bit (mip.mtip) into the CSR/state block.
- Drives the 64-bit time value read through the TIME/TIMEH and CYCLE-style CSRs.
- Sits on the peripheral bus as a 16-byte memory-mapped register window; one instance per hart.

---
 rtl/riscv_mtimer.sv | 111 +++++++++++
 1 files changed

// File: rtl/riscv_mtimer.sv
// ============================================================================
// Module  : riscv_mtimer
// Brief   : Machine timer (mtime/mtimecmp) with a 16-byte bus window and MTIP.
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_mtimer #(
  parameter int unsigned PRESCALE     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        time_en,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [63:0] mtime_o,
  output logic        mtip
);

  localparam logic [15:0] c_presc_max = 16'(PRESCALE - 1);

  logic [15:0] r_presc;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_mtip;

  logic        w_tick;
  logic        w_bad;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_rmux;

  assign w_tick = time_en && (r_presc == c_presc_max);
  assign w_bad  = (addr[1:0] != 2'b00);
  assign w_wr   = req && we && !w_bad;
  assign w_rd   = req && !we && !w_bad;

  // Read data comes from the register state seen at the request edge.
  always_comb begin
    w_rmux = 32'h0;
    case (addr[3:2])
      2'd0:    w_rmux = r_mtime[31:0];
      2'd1:    w_rmux = r_mtime[63:32];
      2'd2:    w_rmux = r_mtimecmp[31:0];
      default: w_rmux = r_mtimecmp[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_presc <= 16'h0;
    end else if (time_en) begin
      r_presc <= w_tick ? 16'h0 : r_presc + 16'h1;
    end
  end

  // A software write to either half wins over a tick: no increment, no carry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mtime <= 64'h0;
    end else if (w_wr && addr[3:2] == 2'd0) begin
      r_mtime <= {r_mtime[63:32], wdata};
    end else if (w_wr && addr[3:2] == 2'd1) begin
      r_mtime <= {wdata, r_mtime[31:0]};
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mtimecmp <= MTIMECMP_RST;
    end else if (w_wr && addr[3:2] == 2'd2) begin
      r_mtimecmp <= {r_mtimecmp[63:32], wdata};
    end else if (w_wr && addr[3:2] == 2'd3) begin
      r_mtimecmp <= {wdata, r_mtimecmp[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
      r_mtip  <= 1'b0;
    end else begin
      r_ack   <= req;
      r_err   <= req && w_bad;
      r_rdata <= w_rd ? w_rmux : 32'h0;
      r_mtip  <= (r_mtime >= r_mtimecmp);
    end
  end

  assign ack     = r_ack;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign mtime_o = r_mtime;
  assign mtip    = r_mtip;

endmodule

`default_nettype wire
